// File: rtl/pattern_stream_source.sv
// Valid/ready stimulus generator: streams beats from a small pattern table,
// an incrementing counter seeded from table entry 0, or an LFSR seeded from
// table entry 0. Supports one-shot and looping passes, idle gaps between
// beats, last-beat framing and done/busy status.
module pattern_stream_source #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int LEN_W      = 16,
  parameter int GAP_W      = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr_en,
  input  logic [AW-1:0]         cfg_wr_addr,
  input  logic [DATA_WIDTH-1:0] cfg_wr_data,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            mode,
  input  logic [LEN_W-1:0]      len,
  input  logic [GAP_W-1:0]      gap,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic [LEN_W-1:0]      beat_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t                  state;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [1:0]              mode_r;
  logic [LEN_W-1:0]        len_r;
  logic [LEN_W-1:0]        k;
  logic [GAP_W-1:0]        gap_r;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    stop_pend;
  logic                    last_r;

  logic                    wr_ok;
  logic [DATA_WIDTH-1:0]   mem0;
  logic [DATA_WIDTH-1:0]   first_data;
  logic [LEN_W-1:0]        eff_len;
  logic                    handshake;
  logic                    loop_on;
  logic [LEN_W-1:0]        k_nxt;
  logic [DATA_WIDTH-1:0]   seq_data;
  logic [DATA_WIDTH-1:0]   nb_data;
  logic                    nb_last;

  // Shift left, feeding back the XOR of the two top bits.
  function automatic logic [DATA_WIDTH-1:0] lfsr_next(input logic [DATA_WIDTH-1:0] cur);
    return {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1] ^ cur[DATA_WIDTH-2]};
  endfunction

  // Table modes can never run past the end of the table.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [1:0] m, input logic [LEN_W-1:0] l);
    if (!m[1] && (l > LEN_W'(DEPTH)))
      return LEN_W'(DEPTH);
    return l;
  endfunction

  // Table writes are frozen while a stream is running, so mem[0] read
  // during a stream is stable; at start a same-cycle write to entry 0 is
  // forwarded so beat 0 sees it.
  assign wr_ok      = cfg_wr_en & ~busy;
  assign mem0       = (wr_ok && (cfg_wr_addr == '0)) ? cfg_wr_data : mem[0];
  assign first_data = ((mode == 2'd3) && (mem0 == '0)) ? DATA_WIDTH'(1) : mem0;
  assign eff_len    = clamp_len(mode, len);
  assign handshake  = out_valid & out_ready;
  assign loop_on    = (mode_r == 2'd1) && !stop_pend && !stop;

  // Next beat's data and framing, computed from the beat now presented.
  always_comb begin
    k_nxt = k + LEN_W'(1);
    case (mode_r)
      2'd2:    seq_data = out_data + DATA_WIDTH'(1);
      2'd3:    seq_data = lfsr_next(out_data);
      default: seq_data = mem[k_nxt[AW-1:0]];
    endcase
    if (out_last) begin
      nb_data = mem[0];
      nb_last = (len_r == LEN_W'(1));
    end else begin
      nb_data = seq_data;
      nb_last = (k_nxt == (len_r - LEN_W'(1)));
    end
  end

  // Pattern table: no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_ok)
      mem[cfg_wr_addr] <= cfg_wr_data;
  end

  // Stream sequencer: IDLE -> SEND (-> GAP -> SEND)* -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      beat_count <= '0;
      mode_r     <= '0;
      len_r      <= '0;
      gap_r      <= '0;
      gap_cnt    <= '0;
      k          <= '0;
      stop_pend  <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && stop && (mode_r == 2'd1))
        stop_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            mode_r     <= mode;
            len_r      <= eff_len;
            gap_r      <= gap;
            beat_count <= '0;
            k          <= '0;
            stop_pend  <= 1'b0;
            if (eff_len != '0) begin
              state     <= SEND;
              busy      <= 1'b1;
              out_valid <= 1'b1;
              out_data  <= first_data;
              out_last  <= (eff_len == LEN_W'(1));
            end else begin
              done <= 1'b1;
            end
          end
        end
        SEND: begin
          if (handshake) begin
            beat_count <= beat_count + LEN_W'(1);
            if (out_last && !loop_on) begin
              state     <= IDLE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
              stop_pend <= 1'b0;
              k         <= '0;
            end else begin
              k        <= out_last ? '0 : k_nxt;
              out_data <= nb_data;
              last_r   <= nb_last;
              if (gap_r == '0) begin
                out_last <= nb_last;
              end else begin
                state     <= GAP;
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                gap_cnt   <= gap_r - GAP_W'(1);
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state     <= SEND;
            out_valid <= 1'b1;
            out_last  <= last_r;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_stream_source.sv
// Directed bench for pattern_stream_source with a spec-level beat model.
module tb_pattern_stream_source;
  localparam int DW  = 8;
  localparam int DEP = 4;
  localparam int LW  = 16;
  localparam int GW  = 4;
  localparam int AW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_wr_en;
  logic [AW-1:0] cfg_wr_addr;
  logic [DW-1:0] cfg_wr_data;
  logic          start;
  logic          stop;
  logic [1:0]    mode;
  logic [LW-1:0] len;
  logic [GW-1:0] gap;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [LW-1:0] beat_count;

  pattern_stream_source #(.DATA_WIDTH(DW), .DEPTH(DEP), .LEN_W(LW), .GAP_W(GW)) dut (
    .clk(clk), .rst(rst), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .start(start), .stop(stop), .mode(mode),
    .len(len), .gap(gap), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
    .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  logic [DW-1:0] tb_mem [DEP];
  logic [DW:0]   expq [$];
  logic          rdy_tab [64];
  logic          stop_tab [64];
  logic          vh [64];
  logic          dh [64];
  logic          bh [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats for 'passes' passes, straight from the beat rules.
  task automatic build(input int m, input int l, input int passes);
    int el;
    logic [DW-1:0] cur;
    el = l;
    if (m < 2 && el > DEP) el = DEP;
    expq.delete();
    cur = '0;
    for (int p = 0; p < passes; p++) begin
      for (int k = 0; k < el; k++) begin
        if (m < 2) cur = tb_mem[k];
        else if (m == 2) cur = DW'((int'(tb_mem[0]) + k) % 256);
        else if (k == 0) cur = (tb_mem[0] == 0) ? DW'(1) : tb_mem[0];
        else cur = DW'(((int'(cur) * 2) % 256) + int'(cur[7] ^ cur[6]));
        expq.push_back({(k == el - 1), cur});
      end
    end
  endtask

  task automatic set_rdy(input logic v);
    for (int i = 0; i < 64; i++) begin
      rdy_tab[i] = v;
      stop_tab[i] = 1'b0;
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    @(posedge clk); #1;
    cfg_wr_en = 1'b1; cfg_wr_addr = AW'(a); cfg_wr_data = d;
    tb_mem[a] = d;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  // Per-cycle compare against the model queue plus history capture.
  task automatic run(input int n);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      vh[i] = out_valid; dh[i] = done; bh[i] = busy;
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("extra_beat", 32'(out_data), 32'hdead);
        end else begin
          chk("beat_data", 32'(out_data), 32'(expq[0][DW-1:0]));
          chk("beat_last", 32'(out_last), 32'(expq[0][DW]));
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (done) chk("done_drained", 32'(expq.size()), 32'd0);
      @(posedge clk); #1;
      out_ready = rdy_tab[i + 1];
      stop = stop_tab[i + 1];
    end
  endtask

  task automatic go(input int m, input int l, input int g, input int n);
    @(posedge clk); #1;
    mode = 2'(m); len = LW'(l); gap = GW'(g); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = rdy_tab[1];
    stop = stop_tab[1];
    run(n);
  endtask

  logic [8:0] gap_pat;

  initial begin
    rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    start = 1'b0; stop = 1'b0; mode = '0; len = '0; gap = '0; out_ready = 1'b0;
    #12;
    chk("rst_data", 32'(out_data), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(beat_count), 0);
    @(posedge clk); #1 rst = 1'b0;

    wr(0, 8'h11); wr(1, 8'h22); wr(2, 8'h33); wr(3, 8'h44);

    // 1: one-shot table, full throughput
    set_rdy(1'b1);
    build(0, 4, 1);
    chk("model_t1_last", 32'(expq[3]), 32'h144);
    go(0, 4, 0, 7);
    for (int i = 1; i <= 4; i++) chk("t1_valid", 32'(vh[i]), 1);
    chk("t1_busy", 32'(bh[1]), 1);
    chk("t1_nodone", 32'(dh[4]), 0);
    chk("t1_done", 32'(dh[5]), 1);
    chk("t1_valid_end", 32'(vh[5]), 0);
    chk("t1_busy_end", 32'(bh[5]), 0);
    chk("t1_count", 32'(beat_count), 4);
    chk("t1_left", 32'(expq.size()), 0);

    // 2: back-pressure on the second beat
    set_rdy(1'b1);
    rdy_tab[2] = 1'b0; rdy_tab[3] = 1'b0; rdy_tab[4] = 1'b0;
    build(0, 4, 1);
    go(0, 4, 0, 10);
    for (int i = 2; i <= 4; i++) chk("t2_hold_valid", 32'(vh[i]), 1);
    chk("t2_done", 32'(dh[8]), 1);
    chk("t2_count", 32'(beat_count), 4);
    chk("t2_left", 32'(expq.size()), 0);

    // 3: gap of two, no gap after the final beat
    set_rdy(1'b1);
    build(0, 3, 1);
    go(0, 3, 2, 10);
    gap_pat = 9'b0_1001_0010;
    for (int i = 1; i <= 8; i++) chk("t3_valid_pat", 32'(vh[i]), 32'(gap_pat[8 - i]));
    chk("t3_nodone", 32'(dh[7]), 0);
    chk("t3_done", 32'(dh[8]), 1);
    chk("t3_left", 32'(expq.size()), 0);

    // 4: loop mode, stop during second pass
    set_rdy(1'b1);
    stop_tab[5] = 1'b1;
    build(1, 3, 2);
    chk("model_t4_size", 32'(expq.size()), 6);
    go(1, 3, 0, 9);
    chk("t4_valid6", 32'(vh[6]), 1);
    chk("t4_done", 32'(dh[7]), 1);
    chk("t4_valid_end", 32'(vh[7]), 0);
    chk("t4_count", 32'(beat_count), 6);
    chk("t4_left", 32'(expq.size()), 0);

    // 5: counter and LFSR modes
    set_rdy(1'b1);
    wr(0, 8'hFE);
    build(2, 4, 1);
    chk("model_cnt2", 32'(expq[2][DW-1:0]), 32'h00);
    chk("model_cnt3", 32'(expq[3]), 32'h101);
    go(2, 4, 0, 6);
    chk("t5_cnt_done", 32'(dh[5]), 1);
    chk("t5_cnt_left", 32'(expq.size()), 0);
    wr(0, 8'h40);
    build(3, 3, 1);
    chk("model_lfsr1", 32'(expq[1][DW-1:0]), 32'h81);
    chk("model_lfsr2", 32'(expq[2][DW-1:0]), 32'h03);
    go(3, 3, 0, 5);
    chk("t5_lfsr_left", 32'(expq.size()), 0);
    wr(0, 8'h00);
    build(3, 2, 1);
    chk("model_lfsr_seed0", 32'(expq[0][DW-1:0]), 32'h01);
    go(3, 2, 0, 4);
    chk("t5_seed0_left", 32'(expq.size()), 0);

    // 6: async reset mid-stream, table retention, len=0, start+write
    wr(0, 8'h11);
    set_rdy(1'b1);
    build(0, 4, 1);
    go(0, 4, 0, 2);
    chk("t6_pre_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(out_valid), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_count", 32'(beat_count), 0);
    chk("t6_rst_last", 32'(out_last), 0);
    expq.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_rst_nodone", 32'(done), 0);
    end
    @(posedge clk); #1 rst = 1'b0;
    build(0, 1, 1);
    chk("model_t6_replay", 32'(expq[0]), 32'h111);
    go(0, 1, 0, 3);
    chk("t6_replay_done", 32'(dh[2]), 1);
    chk("t6_replay_left", 32'(expq.size()), 0);

    build(0, 0, 1);
    go(0, 0, 0, 3);
    chk("t6_len0_done", 32'(dh[1]), 1);
    chk("t6_len0_busy", 32'(bh[1]), 0);
    for (int i = 1; i <= 3; i++) chk("t6_len0_valid", 32'(vh[i]), 0);

    @(posedge clk); #1;
    cfg_wr_en = 1'b1; cfg_wr_addr = '0; cfg_wr_data = 8'h5A;
    mode = 2'd0; len = LW'(1); gap = '0; start = 1'b1;
    tb_mem[0] = 8'h5A;
    build(0, 1, 1);
    @(posedge clk); #1;
    start = 1'b0; cfg_wr_en = 1'b0; out_ready = 1'b1; stop = 1'b0;
    run(3);
    chk("t6_wrstart_done", 32'(dh[2]), 1);
    chk("t6_wrstart_left", 32'(expq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/pattern_stream_source.md
Name: pattern_stream_source

Overview:
- Parametrised valid/ready stream generator used as the stimulus producer in the sync buffer test benches.
- Emits a programmable burst from an internal pattern table, an incrementing counter, or an LFSR.
- Supports one-shot or looping passes, configurable idle gaps between beats, `out_last` framing, and done/busy status.

Parameters:
- DATA_WIDTH, 8: width of each beat.
- DEPTH, 16: pattern table entries. Power of two, ≥2. AW = log2(DEPTH).
- LEN_W, 16: width of the `len` and `beat_count` fields.
- GAP_W, 4: width of the `gap` field.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_wr_en  in  1  pattern table write strobe.
- cfg_wr_addr  in  AW  table write index.
- cfg_wr_data  in  DATA_WIDTH  table write data.
- start  in  1  begin a stream. Sampled only when busy=0.
- stop  in  1  request end of a loop-mode stream.
- mode  in  2  0=table one-shot, 1=table loop, 2=counter, 3=LFSR. Latched at start.
- len  in  LEN_W  beats per pass. Latched at start.
- gap  in  GAP_W  idle cycles after each beat. Latched at start.
- out_data  out  DATA_WIDTH  beat data.
- out_valid  out  1  beat present.
- out_ready  in  1  consumer accepts the beat.
- out_last  out  1  marks the final beat of a pass.
- busy  out  1  stream in progress.
- done  out  1  one-cycle pulse when the stream ends.
- beat_count  out  LEN_W  handshakes since the last start; wraps modulo 2^LEN_W.

Behaviour:
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, done=0, beat_count=0. FSM goes to IDLE, internal index=0, stop-pending cleared. The pattern table is not reset; its contents survive rst.
- Reset mid-stream: outputs take their reset values immediately (asynchronous). No done pulse is generated.
- States: IDLE, SEND, GAP.
- IDLE:
  - start=1 latches mode/len/gap, clears beat_count, and sets busy=1 next cycle.
  - If len≠0, go to SEND. Beat 0 is presented (out_valid=1) in the cycle after start; latency is 1.
  - If len=0: no beats are sent, done pulses in the cycle after start, and the block stays in IDLE with busy=0.
  - start while busy=1 is ignored.
- Table length clamp: in table modes, effective len = min(len, DEPTH).
- Table writes are accepted only while busy=0 and are ignored while busy=1. A write takes effect on the next clock edge.
- SEND:
  - out_valid=1. out_data and out_last are held stable until the handshake (out_valid & out_ready).
  - On handshake, beat_count increments.
    - If the beat was not last and gap=0, the next beat is presented in the following cycle (full throughput, valid stays high).
    - If the beat was not last and gap>0, go to GAP.
- GAP: out_valid=0 for exactly `gap` cycles, then SEND with the next beat.
- Beat k data (k = 0..len-1 within a pass):
  - Table modes: mem[k].
  - Counter mode: (mem[0] + k) mod 2^DATA_WIDTH.
  - LFSR mode:
    - Beat 0 = mem[0], or 1 if mem[0] is zero.
    - next = {cur[DATA_WIDTH-2:0], cur[DATA_WIDTH-1] ^ cur[DATA_WIDTH-2]}.
- out_last=1 only on beat len-1 of each pass.
- End of stream after handshake of the last beat:
  - Modes 0, 2, 3: done pulses for one cycle in the next cycle; busy=0 and out_valid=0 in that same cycle; return to IDLE. The gap is not applied after the final beat.
  - Mode 1 (table loop) without stop pending: index returns to 0 and the next pass begins. The gap rule applies as between any beats. Counter/LFSR state is irrelevant in this mode.
  - Mode 1 with stop pending: end exactly as for modes 0, 2, 3.
- Stop:
  - stop=1 on any cycle while busy sets stop-pending.
  - It is honoured at the next out_last handshake, including a handshake in the same cycle as stop.
  - stop is ignored in modes 0, 2, 3, and ignored while idle.
- Simultaneous start and cfg_wr_en in IDLE: the write lands, and beat 0 reflects the write if its address is 0.

Test Plan:
1. DW=8, DEPTH=4: write 11,22,33,44; mode0, len=4, gap=0, ready=1; start at cycle T → valid with 11,22,33,44 in cycles T+1..T+4; last on 44; done at T+5; beat_count=4; busy=0.
2. Same setup, ready=0 for 3 cycles while 22 is presented → 22 held with valid=1 and last=0 throughout; the stream resumes with 33 after ready rises; still 4 beats total.
3. gap=2, len=3, ready=1 → valid pattern 1,0,0,1,0,0,1, then done on the next cycle; no gap after the last beat.
4. Mode1, len=3, stop pulsed during the second pass → beats 11,22,33,11,22,33 with last on both 33s, then done; beat_count=6.
5. Mode2, mem[0]=FE, len=4 → FE,FF,00,01. Mode3, mem[0]=40, len=3 → 40,81,03. Mode3 with mem[0]=00 → first beat 01.
6. Assert rst while valid=1 mid-stream → out_valid, busy, and beat_count are 0 immediately, no done pulse. Release and restart mode0 → replays 11 (table retained). len=0 start → done pulse only, no valid.
